// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter slice.
package mult_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Requester ID width, never narrower than one bit
    function automatic int unsigned id_w(input int unsigned r);
        int unsigned w;
        w = $clog2(r);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mult_NMbit.sv
// Combinational unsigned N x M multiplier with a full-width N+M product.
module mult_NMbit #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 5
) (
    input  logic [N-1:0]   i_a,
    input  logic [M-1:0]   i_b,
    output logic [N+M-1:0] o_prod_c
);

    localparam int unsigned P_W = N + M;

    assign o_prod_c = P_W'(i_a) * P_W'(i_b);

endmodule

// File: rtl/mult_arb_sel.sv
// Request selector: one-hot grant plus encoded winner index.
// MULT_ARB_ROUND_ROBIN_EN selects round-robin from i_ptr; otherwise fixed lowest-index priority.
module mult_arb_sel
    import mult_arb_pkg::*;
#(
    parameter int unsigned R    = 4,
    parameter int unsigned ID_W = id_w(R)
) (
    input  logic [R-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [R-1:0]    o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    assign o_any = |i_req;

`ifdef MULT_ARB_ROUND_ROBIN_EN
    // Walk offsets from the far end so the nearest requester after i_ptr wins last
    always_comb begin
        int unsigned w_pos;
        logic [ID_W-1:0] w_cand;
        o_grant = '0;
        o_idx   = '0;
        w_pos   = 0;
        w_cand  = '0;
        for (int k = int'(R) - 1; k >= 0; k--) begin
            w_pos  = (32'(i_ptr) + 32'(k)) % R;
            w_cand = ID_W'(w_pos);
            if (i_req[w_cand]) begin
                o_grant         = '0;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    // Descending scan leaves the lowest-index requester as the winner
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int i = int'(R) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_idx      = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mult_arbiter.sv
// Shares one mult_NMbit among R valid/ready requesters behind a single registered result slot.
// MULT_ARB_ROUND_ROBIN_EN enables round-robin arbitration; default is fixed priority.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned M = 5,
    parameter int unsigned R = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [R-1:0]        req_valid,
    output logic [R-1:0]        req_ready,
    input  logic [R*N-1:0]      req_a,
    input  logic [R*M-1:0]      req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [N+M-1:0]      res_prod,
    output logic [id_w(R)-1:0]  res_id,
    output logic                busy
);

    localparam int unsigned ID_W = id_w(R);
    localparam int unsigned P_W  = N + M;

    state_t          r_state;
    logic [P_W-1:0]  r_prod;
    logic [ID_W-1:0] r_id;

    logic [R-1:0]    w_grant;
    logic [ID_W-1:0] w_idx;
    logic [ID_W-1:0] w_ptr;
    logic            w_any;
    logic            w_slot_free;
    logic            w_accept;
    logic [N-1:0]    w_a;
    logic [M-1:0]    w_b;
    logic [P_W-1:0]  w_prod;

    // Slot can take a new result when empty or being drained this cycle
    assign w_slot_free = (r_state == EMPTY) || res_ready;
    assign w_accept    = rst_n && w_slot_free && w_any;
    assign req_ready   = (rst_n && w_slot_free) ? w_grant : '0;

    mult_arb_sel #(
        .R    (R),
        .ID_W (ID_W)
    ) u_sel (
        .i_req   (req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Operand mux steered by the winner index
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_a = req_a[i*N +: N];
                w_b = req_b[i*M +: M];
            end
        end
    end

    mult_NMbit #(
        .N (N),
        .M (M)
    ) u_mult (
        .i_a      (w_a),
        .i_b      (w_b),
        .o_prod_c (w_prod)
    );

`ifdef MULT_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_idx == ID_W'(R - 1)) ? '0 : w_idx + ID_W'(1);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Slot FSM: load on accept, empty on drain with nothing to refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_prod  <= '0;
            r_id    <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= FULL;
                        r_prod  <= w_prod;
                        r_id    <= w_idx;
                    end
                end
                FULL: begin
                    if (w_accept) begin
                        r_prod <= w_prod;
                        r_id   <= w_idx;
                    end else if (res_ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign res_valid = (r_state == FULL);
    assign busy      = (r_state == FULL);
    assign res_prod  = r_prod;
    assign res_id    = r_id;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter (N=4, M=5, R=4).
module tb_mult_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned M = 5;
    localparam int unsigned R = 4;

    logic           clk;
    logic           rst_n;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*M-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [N+M-1:0] res_prod;
    logic [1:0]     res_id;
    logic           busy;

    int n_checks;
    int n_errors;

    mult_arbiter #(.N(N), .M(M), .R(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_prod  (res_prod),
        .res_id    (res_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_op(input int idx, input int a, input int b);
        req_a[idx*N +: N] = N'(a);
        req_b[idx*M +: M] = M'(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] tbl_valid [5];
    int         tbl_id    [5];
    int         tbl_prod  [4];
    logic [3:0] exp_rdy;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        req_valid = 4'b0001;
        set_op(0, 3, 2);

        // Reset state with a pending request
        #3;
        check_eq("rst_ready", 32'(req_ready), 0);
        check_eq("rst_valid", 32'(res_valid), 0);
        check_eq("rst_prod",  32'(res_prod),  0);
        check_eq("rst_id",    32'(res_id),    0);
        check_eq("rst_busy",  32'(busy),      0);
        tick();
        tick();
        check_eq("rst_hold_ready", 32'(req_ready), 0);
        check_eq("rst_hold_valid", 32'(res_valid), 0);

        // Release and first transaction
        #3 rst_n = 1'b1;
        #1 check_eq("first_ready", 32'(req_ready), 32'b0001);
        tick();
        check_eq("first_valid", 32'(res_valid), 1);
        check_eq("first_prod",  32'(res_prod),  6);
        check_eq("first_id",    32'(res_id),    0);
        check_eq("first_busy",  32'(busy),      1);

        // Backpressure: load 15*3 then stall with requester 1 pending
        set_op(0, 15, 3);
        #1 check_eq("bp_load_ready", 32'(req_ready), 32'b0001);
        tick();
        check_eq("bp_load_prod", 32'(res_prod), 45);
        req_valid = 4'b0010;
        set_op(1, 7, 9);
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check_eq("bp_stall_ready", 32'(req_ready), 0);
            tick();
            check_eq("bp_stall_prod",  32'(res_prod),  45);
            check_eq("bp_stall_id",    32'(res_id),    0);
            check_eq("bp_stall_valid", 32'(res_valid), 1);
        end
        res_ready = 1'b1;
        #1 check_eq("bp_drain_ready", 32'(req_ready), 32'b0010);
        tick();
        check_eq("bp_refill_prod",  32'(res_prod),  63);
        check_eq("bp_refill_id",    32'(res_id),    1);
        check_eq("bp_refill_valid", 32'(res_valid), 1);
        req_valid = 4'b0000;
        #1 check_eq("idle_ready", 32'(req_ready), 0);
        tick();
        check_eq("drain_empty_valid", 32'(res_valid), 0);
        check_eq("drain_empty_busy",  32'(busy),      0);

        // Boundary operands
        req_valid = 4'b0100;
        set_op(2, 15, 31);
        tick();
        check_eq("max_prod", 32'(res_prod), 465);
        check_eq("max_id",   32'(res_id),   2);
        set_op(2, 0, 31);
        tick();
        check_eq("zero_prod",  32'(res_prod),  0);
        check_eq("zero_valid", 32'(res_valid), 1);
        req_valid = 4'b0000;
        tick();
        check_eq("boundary_drain", 32'(res_valid), 0);

        // Reset while FULL under backpressure discards the held result
        req_valid = 4'b0010;
        set_op(1, 9, 9);
        res_ready = 1'b0;
        tick();
        check_eq("mid_load_prod", 32'(res_prod), 81);
        req_valid = 4'b0000;
        tick();
        check_eq("mid_held_valid", 32'(res_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(res_valid), 0);
        check_eq("mid_rst_prod",  32'(res_prod),  0);
        check_eq("mid_rst_id",    32'(res_id),    0);
        req_valid = 4'b1000;
        #1 check_eq("mid_rst_ready", 32'(req_ready), 0);
        tick();
        check_eq("mid_rst_edge_valid", 32'(res_valid), 0);
        req_valid = 4'b0000;
        res_ready = 1'b1;
        #3 rst_n = 1'b1;
        tick();
        check_eq("mid_post_valid", 32'(res_valid), 0);
        check_eq("mid_post_prod",  32'(res_prod),  0);

        // Arbitration with all four requesters
        set_op(0, 5, 5);
        set_op(1, 10, 1);
        set_op(2, 2, 3);
        set_op(3, 15, 2);
        tbl_prod[0] = 25;
        tbl_prod[1] = 10;
        tbl_prod[2] = 6;
        tbl_prod[3] = 30;
`ifdef MULT_ARB_ROUND_ROBIN_EN
        tbl_valid[0] = 4'b1111; tbl_id[0] = 0;
        tbl_valid[1] = 4'b1111; tbl_id[1] = 1;
        tbl_valid[2] = 4'b1111; tbl_id[2] = 2;
        tbl_valid[3] = 4'b1111; tbl_id[3] = 3;
        tbl_valid[4] = 4'b1111; tbl_id[4] = 0;
`else
        tbl_valid[0] = 4'b1111; tbl_id[0] = 0;
        tbl_valid[1] = 4'b1111; tbl_id[1] = 0;
        tbl_valid[2] = 4'b1111; tbl_id[2] = 0;
        tbl_valid[3] = 4'b1110; tbl_id[3] = 1;
        tbl_valid[4] = 4'b1110; tbl_id[4] = 1;
`endif
        for (int c = 0; c < 5; c++) begin
            req_valid = tbl_valid[c];
            exp_rdy   = 4'b0001 << tbl_id[c];
            #1 check_eq($sformatf("arb_ready_%0d", c), 32'(req_ready), 32'(exp_rdy));
            tick();
            check_eq($sformatf("arb_id_%0d", c),    32'(res_id),    32'(tbl_id[c]));
            check_eq($sformatf("arb_prod_%0d", c),  32'(res_prod),  32'(tbl_prod[tbl_id[c]]));
            check_eq($sformatf("arb_valid_%0d", c), 32'(res_valid), 1);
        end
        req_valid = 4'b0000;
        tick();
        check_eq("final_empty", 32'(res_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one `mult_NMbit` multiplier instance among R requesters through valid/ready handshakes. The arbiter picks one pending request per cycle. It registers the product and the winner's ID into a single output slot, and presents the result downstream with its own valid/ready handshake. It sits between the requesting datapath blocks and the shared multiplier, so the design needs only one multiplier.

## Interface
- `N`, 4, width of operand A
- `M`, 5, width of operand B
- `R`, 4, number of requesters (≥1)
- `ID_W`, derived, `max(1, $clog2(R))`, width of requester ID
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  R  bit i set: requester i holds a request
- `req_ready`  out  R  one-hot or zero; bit i set: request i accepted this edge
- `req_a`  in  R*N  operand A for requester i at bits [i*N +: N]
- `req_b`  in  R*M  operand B for requester i at bits [i*M +: M]
- `res_valid`  out  1  output slot holds a result
- `res_ready`  in  1  downstream accepts the result
- `res_prod`  out  N+M  unsigned product A*B
- `res_id`  out  ID_W  index of the requester that produced `res_prod`
- `busy`  out  1  equals `res_valid`

## Operation
- FSM with two states, from `mult_arb_pkg::state_t`:
  - EMPTY: no result held.
  - FULL: result held.
- Slot is free when state is EMPTY, or state is FULL with `res_ready` high (drain and refill in the same cycle).
- When the slot is free and any `req_valid` is set:
  - The arbiter selects winner g and raises only `req_ready[g]`.
  - On the edge: `res_prod` ← `req_a[g]` * `req_b[g]`, `res_id` ← g, state ← FULL.
- When the slot is free and no request is pending:
  - On the edge, a FULL slot being drained goes to EMPTY.
  - An EMPTY slot stays EMPTY.
- When state is FULL and `res_ready` is low:
  - All `req_ready` are 0.
  - `res_prod`, `res_id` and `res_valid` hold stable.
- Requesters must hold `req_a`/`req_b` stable while `req_valid` is high and not yet accepted. The block does not check this.
- Arithmetic: unsigned, full N+M-bit product, no truncation or overflow.
- `req_ready` is combinational from `req_valid`, `res_ready`, state and the arbitration pointer. `req_ready` never depends on the operands.
- Reset values:
  - State EMPTY, `res_valid` 0, `res_prod` 0, `res_id` 0, `busy` 0.
  - Round-robin pointer 0.
  - All `req_ready` held at 0 while `rst_n` is low.
- Reset mid-operation: a held result is discarded and never delivered.

## Timing
- Latency: a request accepted at edge k makes `res_valid` high immediately after edge k, i.e. a 1-cycle registered result.
- Throughput: 1 result per cycle while `res_ready` stays high.
- Back-to-back: with FULL and `res_ready` high, the old result drains and a new one loads on the same edge; `res_valid` stays high.
- A requester may drop `req_valid` without being accepted. Dropping has no effect on state.
- `req_valid[i]` and `res_ready` may change simultaneously. Grant is decided from the current-cycle values.

## Configuration
- Macro `MULT_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration.
  - Search starts at pointer p, ascending and wrapping modulo R.
  - After each acceptance, p ← (g+1) mod R.
  - p is unchanged when nothing is accepted.
  - Any continuously requesting client is served within R grants.
- Undefined: fixed priority.
  - The lowest-index valid requester wins.
  - The pointer register is not built.

## Structure
- `mult_arb_pkg` contains:
  - `state_t` enum {EMPTY, FULL}
  - ID-width function `id_w(R)` returning `max(1, $clog2(R))`
- Sub-module `mult_arb_sel`: the R-bit request vector plus the pointer go in; the one-hot grant and encoded winner index come out. This module contains the macro-selected policy.
- `mult_arbiter` instantiates one `mult_arb_sel` and one `mult_NMbit #(N, M)`. The multiplier's A/B inputs are driven from a mux on the winner index.

## Test plan
- Reset, then single request:
  - Assert reset with `req_valid`=0001 and `req_a[0]`=3, `req_b[0]`=2: all `req_ready`=0 and `res_valid`=0.
  - After release: `req_ready`=0001, and next cycle `res_prod`=6, `res_id`=0.
- Backpressure:
  - Load 15*3, hold `res_ready`=0 for 3 cycles with `req_valid`=0010: `res_prod` stays 45 and `req_ready`=0000.
  - Raise `res_ready`: 45 drains and requester 1 loads on the same edge.
- Round robin (macro defined):
  - All four requesters valid continuously with `res_ready`=1.
  - `res_id` sequence is 0,1,2,3,0.
  - Products match each requester's operands, e.g. 5*5=25 and 10*1=10.
- Fixed priority (macro undefined):
  - Same stimulus: `res_id` stays 0 until `req_valid[0]` drops, then 1.
- Boundary operands:
  - A=15, B=31 gives `res_prod`=465 (all N+M bits).
  - A=0, B=31 gives 0.
- Reset mid-operation:
  - Assert `rst_n`=0 while FULL with `res_ready`=0: `res_valid` goes 0 asynchronously and the held result is never output.
  - After release, the pointer restarts at 0.
